// File: rtl/axis_protocol_checker_if.sv
// axis_protocol_checker_if: AXI-Stream bundle with master/slave views.
interface axis_protocol_checker_if #(
    parameter int BUS_WIDTH  = 1,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [BUS_WIDTH*8-1:0]  tdata;
    logic [BUS_WIDTH-1:0]    tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, tdest, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/axis_protocol_checker.sv
// axis_protocol_checker: 2-entry AXIS skid FIFO with sticky handshake-rule flags and saturating counters.
// Optional macro AXIS_CHECK_HALT_EN: any raised flag freezes both sides of the data path until reset.
module axis_protocol_checker #(
    parameter int BUS_WIDTH   = 1,
    parameter int USER_WIDTH  = 1,
    parameter int DEST_WIDTH  = 1,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   arstn,
    axis_protocol_checker_if.slave  s_axis,
    axis_protocol_checker_if.master m_axis,
    output logic                   err_valid_drop,
    output logic                   err_payload_change,
    output logic                   err_keep_zero,
    output logic [COUNT_WIDTH-1:0] beat_count,
    output logic [COUNT_WIDTH-1:0] packet_count
);
    localparam int PW = BUS_WIDTH * 9 + 1 + USER_WIDTH + DEST_WIDTH;

    logic [PW-1:0] mem [2];
    logic [PW-1:0] s_pl;
    logic [PW-1:0] prev_pl;
    logic [1:0]    cnt;
    logic [1:0]    cnt_nxt;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          ready_q;
    logic          stall_q;
    logic          halt;
    logic          wr;
    logic          rd;

`ifdef AXIS_CHECK_HALT_EN
    assign halt = err_valid_drop | err_payload_change | err_keep_zero;
`else
    assign halt = 1'b0;
`endif

    assign s_pl = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tuser, s_axis.tdest};
    // halt is itself registered, so tready still never sees m_axis.tready
    assign s_axis.tready = ready_q & ~halt;
    assign m_axis.tvalid = (cnt != 2'd0) & ~halt;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser, m_axis.tdest} = mem[rd_ptr];
    assign wr      = s_axis.tvalid & s_axis.tready;
    assign rd      = m_axis.tvalid & m_axis.tready;
    assign cnt_nxt = cnt + {1'b0, wr} - {1'b0, rd};

    always_ff @(posedge aclk)
        if (wr) mem[wr_ptr] <= s_pl;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt                <= 2'd0;
            wr_ptr             <= 1'b0;
            rd_ptr             <= 1'b0;
            ready_q            <= 1'b0;
            stall_q            <= 1'b0;
            prev_pl            <= '0;
            err_valid_drop     <= 1'b0;
            err_payload_change <= 1'b0;
            err_keep_zero      <= 1'b0;
            beat_count         <= '0;
            packet_count       <= '0;
        end else begin
            cnt     <= cnt_nxt;
            ready_q <= cnt_nxt != 2'd2;
            if (wr) wr_ptr <= ~wr_ptr;
            if (rd) rd_ptr <= ~rd_ptr;
            stall_q <= s_axis.tvalid & ~s_axis.tready;
            prev_pl <= s_pl;
            if (stall_q & ~s_axis.tvalid) err_valid_drop <= 1'b1;
            if (stall_q & s_axis.tvalid & (s_pl != prev_pl)) err_payload_change <= 1'b1;
            if (wr & ~|s_axis.tkeep) err_keep_zero <= 1'b1;
            if (wr & ~&beat_count) beat_count <= beat_count + COUNT_WIDTH'(1);
            if (wr & s_axis.tlast & ~&packet_count) packet_count <= packet_count + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_axis_protocol_checker.sv
// tb_axis_protocol_checker: directed scenarios for the AXIS checker (COUNT_WIDTH=4 to reach saturation).
module tb_axis_protocol_checker;
`ifdef AXIS_CHECK_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic       aclk = 1'b0;
    logic       arstn = 1'b0;
    logic       err_valid_drop;
    logic       err_payload_change;
    logic       err_keep_zero;
    logic [3:0] beat_count;
    logic [3:0] packet_count;
    logic [7:0] got [$];
    int         checks = 0;
    int         failures = 0;

    axis_protocol_checker_if #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1)) s_axis ();
    axis_protocol_checker_if #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1)) m_axis ();

    axis_protocol_checker #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .COUNT_WIDTH(4)) dut (
        .aclk(aclk),
        .arstn(arstn),
        .s_axis(s_axis),
        .m_axis(m_axis),
        .err_valid_drop(err_valid_drop),
        .err_payload_change(err_payload_change),
        .err_keep_zero(err_keep_zero),
        .beat_count(beat_count),
        .packet_count(packet_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk)
        if (m_axis.tvalid && m_axis.tready) got.push_back(m_axis.tdata);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic l);
        s_axis.tvalid = v;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        s_axis.tuser  = 1'b0;
        s_axis.tdest  = 1'b0;
        m_axis.tready = 1'b0;
        #2;
        check("rst_s_tready", s_axis.tready, 0);
        check("rst_m_tvalid", m_axis.tvalid, 0);
        check("rst_flags", {err_valid_drop, err_payload_change, err_keep_zero}, 0);
        check("rst_beats", beat_count, 0);
        check("rst_packets", packet_count, 0);
        tick();
        tick();
        got.delete();
        arstn = 1'b1;
        check("rel_tready_low", s_axis.tready, 0);
        tick();
        check("rel_tready_high", s_axis.tready, 1);
    endtask

    initial begin
        do_reset();

        // back-to-back: each beat is the head one edge after acceptance
        m_axis.tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b1, i == 8);
            tick();
            check("s1_head", {m_axis.tvalid, m_axis.tdata}, {1'b1, 8'(i)});
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("s1_drained", m_axis.tvalid, 0);
        check("s1_beats", beat_count, 8);
        check("s1_packets", packet_count, 1);
        check("s1_flags", {err_valid_drop, err_payload_change, err_keep_zero}, 0);
        check("s1_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("s1_order", got[i], i + 1);

        // backpressure: two beats fill the FIFO, third waits
        do_reset();
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        tick();
        check("s2_ready_after1", s_axis.tready, 1);
        drive(1'b1, 8'h12, 1'b1, 1'b0);
        tick();
        check("s2_ready_after2", s_axis.tready, 0);
        drive(1'b1, 8'h13, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        check("s2_stalled_ready", s_axis.tready, 0);
        check("s2_head_held", m_axis.tdata, 8'h11);
        m_axis.tready = 1'b1;
        tick();
        check("s2_head2", m_axis.tdata, 8'h12);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("s2_head3", m_axis.tdata, 8'h13);
        tick();
        check("s2_count", got.size(), 3);
        check("s2_order", {got[0], got[1], got[2]}, 24'h111213);
        check("s2_beats", beat_count, 3);
        check("s2_flags", {err_valid_drop, err_payload_change, err_keep_zero}, 0);

        // valid dropped during a stall
        do_reset();
        drive(1'b1, 8'h21, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h23, 1'b1, 1'b1);
        tick();
        check("s3_no_err_yet", err_valid_drop, 0);
        drive(1'b0, 8'h23, 1'b1, 1'b1);
        tick();
        check("s3_valid_drop", err_valid_drop, 1);
        check("s3_other_flags", {err_payload_change, err_keep_zero}, 0);
        check("s3_m_tvalid", m_axis.tvalid, !HALT);

        // payload change during a stall
        do_reset();
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'h02, 1'b1, 1'b0);
        tick();
        drive(1'b1, 8'hA5, 1'b1, 1'b1);
        tick();
        check("s4_no_err_yet", err_payload_change, 0);
        drive(1'b1, 8'h5A, 1'b1, 1'b1);
        tick();
        check("s4_payload_change", err_payload_change, 1);
        check("s4_other_flags", {err_valid_drop, err_keep_zero}, 0);
        check("s4_halt_outputs", {m_axis.tvalid, s_axis.tready}, HALT ? 2'b00 : 2'b10);
        m_axis.tready = 1'b1;
        tick();
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("s4_beats", beat_count, HALT ? 2 : 3);
        check("s4_delivered", got.size(), HALT ? 0 : 3);

        // zero tkeep is flagged but still forwarded
        do_reset();
        m_axis.tready = 1'b1;
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("s5_keep_zero", err_keep_zero, 1);
        check("s5_other_flags", {err_valid_drop, err_payload_change}, 0);
        check("s5_out_valid", m_axis.tvalid, !HALT);
        check("s5_out_beat", {m_axis.tdata, m_axis.tkeep, m_axis.tlast}, {8'h77, 1'b0, 1'b1});
        check("s5_packets", packet_count, 1);

        // saturation at 4'hF
        do_reset();
        m_axis.tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("s6_beats_sat", beat_count, 15);
        check("s6_packets_sat", packet_count, 15);

        // reset mid-packet with beats held and a flag raised
        m_axis.tready = 1'b0;
        drive(1'b1, 8'h31, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h32, 1'b1, 1'b0);
        tick();
        check("s6_pre_flag", err_keep_zero, 1);
        check("s6_pre_valid", m_axis.tvalid, !HALT);
        do_reset();
        m_axis.tready = 1'b1;
        tick();
        tick();
        check("s6_no_partial", m_axis.tvalid, 0);
        check("s6_none_out", got.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
